// File: rtl/countdown_timer.sv
// Loadable down-counter timer with prescaler, pause/hold, abort and optional auto-reload.
// Counts a loaded value (clamped to MAX) down to zero and pulses done on arrival.
module countdown_timer #(
  parameter int WIDTH    = 5,
  parameter int MAX      = 24,
  parameter int PRESCALE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_start,
  input  logic             i_reload,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_counter,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_load_err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V      = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] reload_val;
  logic             reload_flag;
  logic             over_max;
  logic [WIDTH-1:0] clamped_val;

  assign over_max    = (i_load_val > MAX_V);
  assign clamped_val = over_max ? MAX_V : i_load_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_counter   <= '0;
      presc       <= '0;
      reload_val  <= '0;
      reload_flag <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_load_err  <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_load_err <= 1'b0;
      if (enable) begin
        if (i_abort) begin
          state     <= IDLE;
          o_counter <= '0;
          presc     <= '0;
          o_busy    <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              if (i_load) begin
                o_counter  <= clamped_val;
                reload_val <= clamped_val;
                o_load_err <= over_max;
              end else if (i_start) begin
                if (o_counter != '0) begin
                  state       <= RUN;
                  reload_flag <= i_reload;
                  presc       <= '0;
                  o_busy      <= 1'b1;
                end else begin
                  o_done <= 1'b1;
                end
              end
            end
            RUN, HOLD: begin
              // Releasing pause counts immediately, so each HOLD cycle costs exactly one cycle.
              if (i_pause) begin
                state <= HOLD;
              end else begin
                state <= RUN;
                if (presc == PRESC_LAST) begin
                  presc <= '0;
                  if (o_counter == ONE_V) begin
                    o_done <= 1'b1;
                    if (reload_flag) begin
                      o_counter <= reload_val;
                    end else begin
                      o_counter <= '0;
                      state     <= IDLE;
                      o_busy    <= 1'b0;
                    end
                  end else begin
                    o_counter <= o_counter - ONE_V;
                  end
                end else begin
                  presc <= presc + 1'b1;
                end
              end
            end
            default: begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
